pipeline_hazard_sequencer: RTL and testbench
============================================

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: consecutive data-memory wait cycles before forced release; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Clocking/reset (already decided): one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load_hazard  in  1  load-use hazard detected for the instruction in D.
REQ-007 PCSrcE  in  1  taken branch/jump resolved in EX.
REQ-008 dmem_valid_M  in  1  MEM-stage instruction has an outstanding data-memory access.
REQ-009 dmem_ready  in  1  data memory completes the access this cycle.
REQ-010 imem_ready  in  1  instruction memory delivers the fetch this cycle.
REQ-011 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-012 FlushD, FlushE, FlushW  out  1 each  load a bubble into the corresponding pipeline register.
REQ-013 mem_timeout  out  1  one-cycle pulse on forced memory release.
REQ-014 state  out  2  FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FETCH_WAIT=3.
REQ-015 stall_cycles  out  CNT_W  count of cycles with StallF=1.
REQ-016 flush_events  out  CNT_W  count of cycles with FlushE=1 caused by PCSrcE.

Function
REQ-017 Control outputs SHALL be combinational from inputs and state, with the same-cycle effect described below; state, the wait counter and the perf counters SHALL be registered.
REQ-018 Priority 1, memory wait: dmem_valid_M=1 and dmem_ready=0 and not timing out SHALL assert StallF, StallD, StallE, StallM and FlushW, with FlushD=FlushE=0; PCSrcE and load_hazard are ignored. Next state: MEM_WAIT.
REQ-019 Priority 2, redirect: PCSrcE=1 SHALL assert FlushD and FlushE with all stalls 0, overriding load_hazard and imem_ready. Next state: RUN.
REQ-020 Priority 3, load-use: load_hazard=1 SHALL assert StallF, StallD and FlushE. Next state: LOAD_STALL.
REQ-021 Priority 4, fetch wait: imem_ready=0 SHALL assert StallF and FlushD. Next state: FETCH_WAIT.
REQ-022 With none of the above, all control outputs SHALL be 0. Next state: RUN.
REQ-023 Wait counter SHALL clear on any cycle not in the REQ-018 condition and increment on each REQ-018 cycle.
REQ-024 Timeout: on the MEM_TIMEOUT-th consecutive cycle with dmem_valid_M=1 and dmem_ready=0, the block SHALL pulse mem_timeout=1, assert FlushW only, deassert all stalls, clear the wait counter and go to RUN.
REQ-025 In the cycle after a timeout, dmem_valid_M SHALL be treated as a new access.
REQ-026 dmem_ready=1 in MEM_WAIT SHALL release all stalls in that same cycle; normal priority evaluation then applies.
REQ-027 Perf counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 While rst=1: state=RUN, wait counter=0, stall_cycles=0, flush_events=0, mem_timeout=0, all stalls 0, FlushD=FlushE=FlushW=1 (pipeline drained).
REQ-029 Reset asserted mid-MEM_WAIT SHALL abandon the wait without a mem_timeout pulse.

Structure
REQ-030 State encodings and default MEM_TIMEOUT SHALL live in the shared core package.
REQ-031 One sub-module, sat_counter (CNT_W, saturating increment enable), SHALL be instantiated twice for the perf counters.
REQ-032 The existing load-use detector SHALL remain external and drive load_hazard.

Verification
REQ-033 load_hazard=1 for one cycle -> StallF=StallD=FlushE=1 that cycle, state=1 next cycle, stall_cycles+1.
REQ-034 load_hazard=1 and PCSrcE=1 together -> FlushD=FlushE=1, StallF=0, flush_events+1.
REQ-035 dmem_valid_M=1, dmem_ready=0 for 3 cycles then 1 -> StallF..StallM=1 for exactly 3 cycles, released on the 4th, no mem_timeout pulse.
REQ-036 dmem_ready held 0 with MEM_TIMEOUT=16 -> stalls on cycles 1-15; cycle 16 gives mem_timeout=1, FlushW=1, stalls 0.
REQ-037 rst pulsed during MEM_WAIT -> next cycle state=0, counters 0, no mem_timeout pulse.
REQ-038 Force stall_cycles near all-ones with CNT_W=4 -> it holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings, default memory timeout,
// and the bundle of pipeline control outputs.
package pipeline_hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2,
    StFetchWait = 2'd3
  } state_e;

  localparam int unsigned MemTimeoutDefault = 16;
  // Wide enough for the largest legal timeout (255).
  localparam int unsigned WaitCntW          = 8;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
    logic mem_timeout;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: prioritises memory wait, redirect, load-use and fetch wait into
// stall/flush controls, with a bounded data-memory wait and saturating perf counters.
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_hazard,
  input  logic             PCSrcE,
  input  logic             dmem_valid_M,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  state_e              state_d;
  state_e              state_q;
  logic [WaitCntW-1:0] wait_cnt_d;
  logic [WaitCntW-1:0] wait_cnt_q;
  ctrl_t               ctrl;
  logic                mem_pending;
  logic                timeout_hit;
  logic                flush_inc;

  assign mem_pending = dmem_valid_M & ~dmem_ready;
  // The wait counter holds the number of wait cycles already spent, so the
  // MEM_TIMEOUT-th consecutive wait cycle sees MEM_TIMEOUT-1.
  assign timeout_hit = mem_pending && (wait_cnt_q == WaitCntW'(MEM_TIMEOUT - 1));

  always_comb begin
    ctrl       = '0;
    state_d    = StRun;
    wait_cnt_d = '0;
    flush_inc  = 1'b0;
    if (rst) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (mem_pending && !timeout_hit) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
      state_d      = StMemWait;
      wait_cnt_d   = wait_cnt_q + WaitCntW'(1);
    end else if (timeout_hit) begin
      ctrl.flush_w     = 1'b1;
      ctrl.mem_timeout = 1'b1;
    end else if (PCSrcE) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      flush_inc    = 1'b1;
    end else if (load_hazard) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
      state_d      = StLoadStall;
    end else if (!imem_ready) begin
      ctrl.stall_f = 1'b1;
      ctrl.flush_d = 1'b1;
      state_d      = StFetchWait;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign StallF      = ctrl.stall_f;
  assign StallD      = ctrl.stall_d;
  assign StallE      = ctrl.stall_e;
  assign StallM      = ctrl.stall_m;
  assign FlushD      = ctrl.flush_d;
  assign FlushE      = ctrl.flush_e;
  assign FlushW      = ctrl.flush_w;
  assign mem_timeout = ctrl.mem_timeout;
  assign state       = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (ctrl.stall_f),
    .count_o(stall_cycles)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (flush_inc),
    .count_o(flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a negedge monitor compares.
module tb_pipeline_hazard_sequencer;

  typedef struct {
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  localparam logic [7:0] CRst  = 8'b0000_1110;
  localparam logic [7:0] CNone = 8'b0000_0000;
  localparam logic [7:0] CLu   = 8'b1100_0100;
  localparam logic [7:0] CBr   = 8'b0000_1100;
  localparam logic [7:0] CMw   = 8'b1111_0010;
  localparam logic [7:0] CFw   = 8'b1000_1000;
  localparam logic [7:0] CTo   = 8'b0000_0011;

  logic clk = 1'b0;
  logic rst, load_hazard, PCSrcE, dmem_valid_M, dmem_ready, imem_ready;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;

  logic rst2;
  logic s2_sf, s2_sd, s2_se, s2_sm, s2_fd, s2_fe, s2_fw, s2_to;
  logic [1:0] s2_state;
  logic [3:0] s2_sc, s2_flush;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .MEM_TIMEOUT(16),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_hazard (load_hazard),
    .PCSrcE      (PCSrcE),
    .dmem_valid_M(dmem_valid_M),
    .dmem_ready  (dmem_ready),
    .imem_ready  (imem_ready),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .mem_timeout (mem_timeout),
    .state       (state),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  // Narrow-counter instance held in a permanent load-use stall to exercise saturation.
  pipeline_hazard_sequencer #(
    .MEM_TIMEOUT(16),
    .CNT_W      (4)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst2),
    .load_hazard (1'b1),
    .PCSrcE      (1'b0),
    .dmem_valid_M(1'b0),
    .dmem_ready  (1'b1),
    .imem_ready  (1'b1),
    .StallF      (s2_sf),
    .StallD      (s2_sd),
    .StallE      (s2_se),
    .StallM      (s2_sm),
    .FlushD      (s2_fd),
    .FlushE      (s2_fe),
    .FlushW      (s2_fw),
    .mem_timeout (s2_to),
    .state       (s2_state),
    .stall_cycles(s2_sc),
    .flush_events(s2_flush)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctrl", {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout},
            {24'd0, e.ctrl});
      check("state", {30'd0, state}, {30'd0, e.st});
      check("stall_cycles", stall_cycles, e.sc);
      check("flush_events", flush_events, e.fe);
    end
  end

  task automatic vec(input logic r, input logic lh, input logic pc, input logic dv,
                     input logic dr, input logic ir, input logic [7:0] c, input logic [1:0] s,
                     input int sc, input int fe);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    load_hazard  = lh;
    PCSrcE       = pc;
    dmem_valid_M = dv;
    dmem_ready   = dr;
    imem_ready   = ir;
    e.ctrl = c;
    e.st   = s;
    e.sc   = sc;
    e.fe   = fe;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; load_hazard = 1'b0; PCSrcE = 1'b0;
    dmem_valid_M = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);

    //  r  lh pc dv dr ir   ctrl  st   sc  fe
    vec(1, 0, 0, 0, 0, 1, CRst,  2'd0, 0, 0);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd0, 0, 0);
    vec(0, 1, 0, 0, 0, 1, CLu,   2'd0, 0, 0);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd1, 1, 0);
    vec(0, 1, 1, 0, 0, 1, CBr,   2'd0, 1, 0);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd0, 1, 1);
    vec(0, 0, 0, 0, 0, 0, CFw,   2'd0, 1, 1);
    vec(0, 1, 0, 0, 0, 0, CLu,   2'd3, 2, 1);
    vec(0, 0, 1, 0, 0, 0, CBr,   2'd1, 3, 1);
    // Three wait cycles (redirect/load-use ignored), released on the fourth.
    vec(0, 1, 1, 1, 0, 1, CMw,   2'd0, 3, 2);
    vec(0, 0, 0, 1, 0, 1, CMw,   2'd2, 4, 2);
    vec(0, 0, 0, 1, 0, 1, CMw,   2'd2, 5, 2);
    vec(0, 0, 0, 1, 1, 1, CNone, 2'd2, 6, 2);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd0, 6, 2);
    // Held wait: 15 stall cycles, timeout on the 16th.
    for (int k = 1; k <= 15; k++) begin
      vec(0, 0, 0, 1, 0, 1, CMw, (k == 1) ? 2'd0 : 2'd2, 6 + k - 1, 2);
    end
    vec(0, 0, 1, 1, 0, 1, CTo,   2'd2, 21, 2);
    vec(0, 0, 0, 1, 0, 1, CMw,   2'd0, 21, 2);
    // Reset mid-wait abandons it; the next wait must count from scratch.
    vec(1, 0, 0, 1, 0, 1, CRst,  2'd2, 22, 2);
    for (int k = 1; k <= 15; k++) begin
      vec(0, 0, 0, 1, 0, 1, CMw, (k == 1) ? 2'd0 : 2'd2, k - 1, 0);
    end
    vec(0, 0, 0, 1, 0, 1, CTo,   2'd2, 15, 0);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd0, 15, 0);
    vec(0, 1, 0, 1, 1, 1, CLu,   2'd0, 15, 0);
    vec(0, 0, 0, 0, 0, 1, CNone, 2'd1, 16, 0);

    @(posedge clk);
    #1;
    load_hazard = 1'b0; PCSrcE = 1'b0; dmem_valid_M = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    // Saturation: 14 stall cycles give 14, one more gives 15, further ones hold at 15.
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("sat_14", {28'd0, s2_sc}, 32'd14);
    @(posedge clk);
    @(negedge clk);
    check("sat_15", {28'd0, s2_sc}, 32'd15);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_hold", {28'd0, s2_sc}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
